// File: rtl/serv_ifetch_pkg.sv
// serv_ifetch_pkg: shared state encoding and opcode constants for the fetch unit.
// Used by serv_ifetch and serv_ifetch_wdog.
package serv_ifetch_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REQ2 = 2'd2,
        HOLD = 2'd3
    } state_e;

    localparam logic [1:0] C_OPC_UNCOMP = 2'b11;

endpackage

// File: rtl/serv_ifetch_wdog.sv
// serv_ifetch_wdog: bus-wait watchdog; o_expire flags the last allowed wait cycle.
// TIMEOUT = 0 disables expiry.
module serv_ifetch_wdog #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic clk,
    input  logic i_rst,
    input  logic clr,
    input  logic en,
    output logic o_expire
);

    localparam logic [TO_W-1:0] LAST =
        (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Expire on the TIMEOUT-th bus cycle so the request drops right after it.
    assign o_expire = (TIMEOUT != 0) && en && (cnt_q == LAST);

endmodule

// File: rtl/serv_ifetch.sv
// serv_ifetch: Wishbone-classic instruction fetch with one-entry output buffer.
// Define SERV_IFETCH_ALIGN_EN to support halfword-aligned (compressed) fetches.
module serv_ifetch
    import serv_ifetch_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned TO_W     = 8,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_fetch,
    input  logic [31:0] i_pc,
    input  logic        i_flush,
    output logic [31:0] o_ibus_adr,
    output logic        o_ibus_cyc,
    input  logic [31:0] i_ibus_rdt,
    input  logic        i_ibus_ack,
    output logic [31:0] o_instr,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic        o_busy,
    output logic        o_fetch_err
);

    state_e      state_q;
    logic [31:0] adr_q;
    logic [31:0] instr_q;
    logic        valid_q;
    logic        cyc_q;
    logic        err_q;
    logic        wd_en;
    logic        wd_clr;
    logic        wd_expire;
    logic        start;

`ifdef SERV_IFETCH_ALIGN_EN
    logic [15:0] half_q;
    logic        mis_q;
    logic        unused;
    assign unused = i_pc[0];
`else
    logic        unused;
    assign unused = ^i_pc[1:0];
`endif

    assign wd_en  = (state_q == REQ) || (state_q == REQ2);
    assign wd_clr = i_flush || i_ibus_ack || !wd_en;

    serv_ifetch_wdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_wdog (
        .clk      (clk),
        .i_rst    (i_rst),
        .clr      (wd_clr),
        .en       (wd_en),
        .o_expire (wd_expire)
    );

    assign start = i_fetch &&
                   (i_flush || state_q == IDLE ||
                    (state_q == HOLD && i_instr_ready));

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            adr_q   <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
            cyc_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef SERV_IFETCH_ALIGN_EN
            half_q  <= '0;
            mis_q   <= 1'b0;
`endif
        end else begin
            err_q <= 1'b0;
            if (i_flush) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
                cyc_q   <= 1'b0;
`ifdef SERV_IFETCH_ALIGN_EN
                half_q  <= '0;
`endif
            end else begin
                unique case (state_q)
                    REQ: begin
                        if (i_ibus_ack) begin
`ifdef SERV_IFETCH_ALIGN_EN
                            if (mis_q && i_ibus_rdt[17:16] == C_OPC_UNCOMP) begin
                                half_q  <= i_ibus_rdt[31:16];
                                adr_q   <= adr_q + 32'd4;
                                state_q <= REQ2;
                            end else begin
                                instr_q <= mis_q ? {16'h0, i_ibus_rdt[31:16]}
                                                 : i_ibus_rdt;
                                valid_q <= 1'b1;
                                cyc_q   <= 1'b0;
                                state_q <= HOLD;
                            end
`else
                            instr_q <= i_ibus_rdt;
                            valid_q <= 1'b1;
                            cyc_q   <= 1'b0;
                            state_q <= HOLD;
`endif
                        end else if (wd_expire) begin
                            cyc_q   <= 1'b0;
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                    REQ2: begin
`ifdef SERV_IFETCH_ALIGN_EN
                        if (i_ibus_ack) begin
                            instr_q <= {i_ibus_rdt[15:0], half_q};
                            valid_q <= 1'b1;
                            cyc_q   <= 1'b0;
                            state_q <= HOLD;
                        end else if (wd_expire) begin
                            cyc_q   <= 1'b0;
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                        end
`else
                        cyc_q   <= 1'b0;
                        state_q <= IDLE;
`endif
                    end
                    HOLD: begin
                        if (i_instr_ready) begin
                            valid_q <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
            // A new fetch overrides whatever the current state decided.
            if (start) begin
                adr_q   <= {i_pc[31:2], 2'b00};
                cyc_q   <= 1'b1;
                state_q <= REQ;
`ifdef SERV_IFETCH_ALIGN_EN
                mis_q   <= i_pc[1];
`endif
            end
        end
    end

    assign o_ibus_adr    = adr_q;
    assign o_ibus_cyc    = cyc_q;
    assign o_instr       = instr_q;
    assign o_instr_valid = valid_q;
    assign o_fetch_err   = err_q;
    assign o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_serv_ifetch.sv
// tb_serv_ifetch: directed scoreboard bench for serv_ifetch (TIMEOUT=4).
// Halfword-fetch steps are built when SERV_IFETCH_ALIGN_EN is defined.
module tb_serv_ifetch;

    localparam logic [31:0] RPC = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_fetch = 1'b0;
    logic [31:0] i_pc = '0;
    logic        i_flush = 1'b0;
    logic [31:0] o_ibus_adr;
    logic        o_ibus_cyc;
    logic [31:0] i_ibus_rdt = '0;
    logic        i_ibus_ack = 1'b0;
    logic [31:0] o_instr;
    logic        o_instr_valid;
    logic        i_instr_ready = 1'b0;
    logic        o_busy;
    logic        o_fetch_err;

    int checks = 0;
    int failures = 0;
    logic [31:0] sb[$];

    serv_ifetch #(
        .TIMEOUT  (4),
        .TO_W     (3),
        .RESET_PC (RPC)
    ) dut (
        .clk           (clk),
        .i_rst         (i_rst),
        .i_fetch       (i_fetch),
        .i_pc          (i_pc),
        .i_flush       (i_flush),
        .o_ibus_adr    (o_ibus_adr),
        .o_ibus_cyc    (o_ibus_cyc),
        .i_ibus_rdt    (i_ibus_rdt),
        .i_ibus_ack    (i_ibus_ack),
        .o_instr       (o_instr),
        .o_instr_valid (o_instr_valid),
        .i_instr_ready (i_instr_ready),
        .o_busy        (o_busy),
        .o_fetch_err   (o_fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    // The PC stage must only request a fetch when the unit can take it.
    always @(posedge clk) begin
        if (!i_rst && i_fetch) begin
            checks++;
            assert (!o_busy || i_flush || (o_instr_valid && i_instr_ready))
            else begin
                failures++;
                $error("FAIL fetch_legal observed=busy expected=idle_or_handshake");
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp_v);
        end
    endtask

    // Compare the buffered instruction against the oldest scoreboard entry.
    task automatic take(input string tag);
        logic [31:0] e;
        if (sb.size() == 0) e = 32'hxxxx_xxxx;
        else e = sb.pop_front();
        chk({tag, "_valid"}, {31'd0, o_instr_valid}, 32'd1);
        chk({tag, "_instr"}, o_instr, e);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_cyc", {31'd0, o_ibus_cyc}, 32'd0);
        chk("rst_valid", {31'd0, o_instr_valid}, 32'd0);
        chk("rst_err", {31'd0, o_fetch_err}, 32'd0);
        chk("rst_instr", o_instr, 32'd0);
        chk("rst_adr", o_ibus_adr, RPC);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        i_rst = 1'b0;
        tick();

        // Basic fetch, ack on the third REQ cycle.
        i_fetch = 1'b1;
        i_pc = 32'h0000_1004;
        tick();
        i_fetch = 1'b0;
        chk("f1_adr", o_ibus_adr, 32'h0000_1004);
        chk("f1_cyc1", {31'd0, o_ibus_cyc}, 32'd1);
        tick();
        chk("f1_cyc2", {31'd0, o_ibus_cyc}, 32'd1);
        chk("f1_novalid", {31'd0, o_instr_valid}, 32'd0);
        tick();
        chk("f1_cyc3", {31'd0, o_ibus_cyc}, 32'd1);
        i_ibus_ack = 1'b1;
        i_ibus_rdt = 32'h0010_0093;
        sb.push_back(32'h0010_0093);
        tick();
        i_ibus_ack = 1'b0;
        i_ibus_rdt = '0;
        chk("f1_cyc_drop", {31'd0, o_ibus_cyc}, 32'd0);
        chk("f1_valid", {31'd0, o_instr_valid}, 32'd1);
        tick();
        tick();
        chk("f1_hold_valid", {31'd0, o_instr_valid}, 32'd1);
        chk("f1_hold_instr", o_instr, 32'h0010_0093);

        // Accept with a back-to-back fetch in the same cycle.
        take("f1");
        i_instr_ready = 1'b1;
        i_fetch = 1'b1;
        i_pc = 32'h0000_1008;
        tick();
        i_instr_ready = 1'b0;
        i_fetch = 1'b0;
        chk("b2b_valid", {31'd0, o_instr_valid}, 32'd0);
        chk("b2b_cyc", {31'd0, o_ibus_cyc}, 32'd1);
        chk("b2b_adr", o_ibus_adr, 32'h0000_1008);
        i_ibus_ack = 1'b1;
        i_ibus_rdt = 32'h0020_0113;
        sb.push_back(32'h0020_0113);
        tick();
        i_ibus_ack = 1'b0;
        take("b2b");
        i_instr_ready = 1'b1;
        tick();
        i_instr_ready = 1'b0;
        chk("b2b_idle", {31'd0, o_busy}, 32'd0);
        chk("b2b_drop", {31'd0, o_instr_valid}, 32'd0);

        // Watchdog: no ack for TIMEOUT cycles.
        i_fetch = 1'b1;
        i_pc = 32'h0000_100C;
        tick();
        i_fetch = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("wd_cyc%0d", k), {31'd0, o_ibus_cyc}, 32'd1);
            chk($sformatf("wd_err%0d", k), {31'd0, o_fetch_err}, 32'd0);
            tick();
        end
        chk("wd_cyc_drop", {31'd0, o_ibus_cyc}, 32'd0);
        chk("wd_err_pulse", {31'd0, o_fetch_err}, 32'd1);
        chk("wd_idle", {31'd0, o_busy}, 32'd0);
        chk("wd_novalid", {31'd0, o_instr_valid}, 32'd0);
        // Stray ack while idle must be ignored.
        i_ibus_ack = 1'b1;
        i_ibus_rdt = 32'h1234_5678;
        tick();
        i_ibus_ack = 1'b0;
        chk("wd_err_end", {31'd0, o_fetch_err}, 32'd0);
        chk("stray_valid", {31'd0, o_instr_valid}, 32'd0);
        chk("stray_instr", o_instr, 32'h0020_0113);

        // Flush with a simultaneous ack.
        i_fetch = 1'b1;
        i_pc = 32'h0000_1010;
        tick();
        i_fetch = 1'b0;
        i_flush = 1'b1;
        i_ibus_ack = 1'b1;
        i_ibus_rdt = 32'hDEAD_BEEF;
        tick();
        i_flush = 1'b0;
        i_ibus_ack = 1'b0;
        chk("fl_cyc", {31'd0, o_ibus_cyc}, 32'd0);
        chk("fl_valid", {31'd0, o_instr_valid}, 32'd0);
        chk("fl_instr", o_instr, 32'h0020_0113);
        tick();
        chk("fl_valid2", {31'd0, o_instr_valid}, 32'd0);

        // Flush and fetch together during REQ.
        i_fetch = 1'b1;
        i_pc = 32'h0000_1010;
        tick();
        i_flush = 1'b1;
        i_pc = 32'h0000_1014;
        tick();
        i_flush = 1'b0;
        i_fetch = 1'b0;
        chk("flf_cyc", {31'd0, o_ibus_cyc}, 32'd1);
        chk("flf_adr", o_ibus_adr, 32'h0000_1014);
        i_ibus_ack = 1'b1;
        i_ibus_rdt = 32'h0000_0033;
        sb.push_back(32'h0000_0033);
        tick();
        i_ibus_ack = 1'b0;
        take("flf");
        // Flush while holding drops the buffered word.
        i_flush = 1'b1;
        void'(sb.pop_back());
        tick();
        i_flush = 1'b0;
        chk("flh_valid", {31'd0, o_instr_valid}, 32'd0);
        chk("flh_busy", {31'd0, o_busy}, 32'd0);

        // Asynchronous reset in the middle of a request.
        i_fetch = 1'b1;
        i_pc = 32'h0000_1018;
        tick();
        i_fetch = 1'b0;
        #2;
        i_rst = 1'b1;
        #1;
        chk("arst_cyc", {31'd0, o_ibus_cyc}, 32'd0);
        chk("arst_adr", o_ibus_adr, RPC);
        tick();
        i_rst = 1'b0;
        i_ibus_ack = 1'b1;
        i_ibus_rdt = 32'hCAFE_F00D;
        tick();
        i_ibus_ack = 1'b0;
        chk("arst_valid", {31'd0, o_instr_valid}, 32'd0);
        chk("arst_busy", {31'd0, o_busy}, 32'd0);

`ifdef SERV_IFETCH_ALIGN_EN
        // Compressed instruction in the upper half.
        i_fetch = 1'b1;
        i_pc = 32'h0000_2002;
        tick();
        i_fetch = 1'b0;
        chk("al1_adr", o_ibus_adr, 32'h0000_2000);
        i_ibus_ack = 1'b1;
        i_ibus_rdt = 32'h4501_0000;
        sb.push_back(32'h0000_4501);
        tick();
        i_ibus_ack = 1'b0;
        chk("al1_cyc", {31'd0, o_ibus_cyc}, 32'd0);
        take("al1");
        i_instr_ready = 1'b1;
        tick();
        i_instr_ready = 1'b0;

        // Full-size instruction straddling the wrap to address zero.
        i_fetch = 1'b1;
        i_pc = 32'hFFFF_FFFE;
        tick();
        i_fetch = 1'b0;
        chk("al2_adr1", o_ibus_adr, 32'hFFFF_FFFC);
        i_ibus_ack = 1'b1;
        i_ibus_rdt = 32'h0093_0000;
        tick();
        chk("al2_adr2", o_ibus_adr, 32'h0000_0000);
        chk("al2_cyc2", {31'd0, o_ibus_cyc}, 32'd1);
        chk("al2_novalid", {31'd0, o_instr_valid}, 32'd0);
        i_ibus_rdt = 32'h0000_0010;
        sb.push_back(32'h0010_0093);
        tick();
        i_ibus_ack = 1'b0;
        take("al2");
        i_instr_ready = 1'b1;
        tick();
        i_instr_ready = 1'b0;
`else
        // Low PC bits are ignored; the raw word comes back.
        i_fetch = 1'b1;
        i_pc = 32'h0000_2003;
        tick();
        i_fetch = 1'b0;
        chk("raw_adr", o_ibus_adr, 32'h0000_2000);
        i_ibus_ack = 1'b1;
        i_ibus_rdt = 32'h4501_0000;
        sb.push_back(32'h4501_0000);
        tick();
        i_ibus_ack = 1'b0;
        take("raw");
        i_instr_ready = 1'b1;
        tick();
        i_instr_ready = 1'b0;
`endif
        chk("sb_empty", sb.size(), 32'd0);
        chk("end_idle", {31'd0, o_busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
